data_sync_tx_arbiter: RTL

Source-domain scheduler that shares one DATA_SYNC multi-bit CDC channel between NUM_REQ requesters. It arbitrates round-robin and registers the winner's word onto unsync_bus. It then drives bus_enable high for a fixed hold window, followed by a low gap, so the destination-side synchronizer sees exactly one clean rising edge per word while the bus is stable. It is the only driver of DATA_SYNC's unsync_bus/bus_enable inputs.

---
 rtl/data_sync_pkg.sv | 22 ++
 rtl/data_sync_tx_arbiter_rr.sv | 41 ++++
 rtl/data_sync_tx_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/data_sync_pkg.sv
// Shared definitions for the DATA_SYNC channel and its source-side scheduler.
// State encoding, sizing helper and common default widths.
package data_sync_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int NUM_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    GAP  = 2'd3
  } tx_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/data_sync_tx_arbiter_rr.sv
// Round-robin winner select with a registered rotating pointer.
// Scan order is ptr, ptr+1, ... wrapping at NUM_REQ.
module rr_arbiter
  import data_sync_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_REQ-1:0] req,
  input  logic               upd,
  output logic [IW-1:0]      win,
  output logic               any
);

  logic [IW-1:0] ptr;
  int            j;

  assign any = |req;

  // Walk offsets high to low so the lowest offset from ptr wins.
  always_comb begin
    win = '0;
    j   = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j]) win = IW'(j);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr <= '0;
    end else if (upd) begin
      ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/data_sync_tx_arbiter.sv
// Source-side scheduler sharing one DATA_SYNC channel between requesters.
// Registers the winner's word, then a fixed enable hold and low gap.
module data_sync_tx_arbiter
  import data_sync_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  localparam int IW = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ)
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [IW-1:0]                 grant_id,
  output logic                          busy,
  output logic [DATA_WIDTH-1:0]         unsync_bus,
  output logic                          bus_enable
);

  localparam int MX =
    (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = clog2(MX + 1);

  if (NUM_REQ < 2 || HOLD_CYCLES < 1 || GAP_CYCLES < 1) begin : g_chk
    $error("data_sync_tx_arbiter: illegal parameters");
  end

  tx_state_e             state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [DATA_WIDTH-1:0] bus_n;
  logic                  en_n, busy_n;
  logic [NUM_REQ-1:0]    ack_n;
  logic [IW-1:0]         gid_n;
  logic [IW-1:0]         win;
  logic                  any, upd;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .CLK (CLK),
    .RST (RST),
    .req (req),
    .upd (upd),
    .win (win),
    .any (any)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bus_n   = unsync_bus;
    en_n    = bus_enable;
    ack_n   = '0;
    gid_n   = grant_id;
    busy_n  = busy;
    upd     = 1'b0;
    unique case (state)
      IDLE: begin
        if (any) begin
          state_n = LOAD;
          bus_n   = req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
          gid_n   = win;
          ack_n   = NUM_REQ'(1) << win;
          busy_n  = 1'b1;
          upd     = 1'b1;
        end
      end
      LOAD: begin
        en_n    = 1'b1;
        cnt_n   = CW'(HOLD_CYCLES - 1);
        state_n = HOLD;
      end
      HOLD: begin
        if (cnt == '0) begin
          en_n    = 1'b0;
          cnt_n   = CW'(GAP_CYCLES - 1);
          state_n = GAP;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      GAP: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (any) begin
          state_n = LOAD;
          bus_n   = req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
          gid_n   = win;
          ack_n   = NUM_REQ'(1) << win;
          busy_n  = 1'b1;
          upd     = 1'b1;
        end else begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      unsync_bus <= '0;
      bus_enable <= 1'b0;
      req_ack    <= '0;
      grant_id   <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      unsync_bus <= bus_n;
      bus_enable <= en_n;
      req_ack    <= ack_n;
      grant_id   <= gid_n;
      busy       <= busy_n;
    end
  end

endmodule
